arashi_ctrl_encoder: RTL

- Initiator-side generator of the 4-bit ctrl word that the downstream ctrl decoder consumes.
- Ctrl bit map:
  - ctrl[1] = write enable.
  - ctrl[0] = read enable.
  - ctrl[3] = write id, valid only with ctrl[1].
  - ctrl[2] = read id, valid only with ctrl[0].
- Accepts independent write and read requests over valid/ready handshakes and queues each direction in its own FIFO.
- Issues one registered ctrl word per cycle. A word may carry one write, one read, or both.
- Honours downstream stall.

---
 rtl/arashi_ctrl_encoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/arashi_ctrl_encoder.sv
// Initiator-side ctrl word generator: per-direction id FIFOs feeding a registered 4-bit ctrl word.
// Define ARASHI_CTRL_ENC_EXCL_EN to make write and read mutually exclusive per word (round-robin).

module arashi_ctrl_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_id,
  input  logic             i_pop,
  output logic             o_ready,
  output logic             o_head,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;

  // Ready depends on the registered count only, so a same-cycle pop never frees a slot early
  assign o_ready = (r_cnt != CNT_W'(DEPTH));
  assign w_push  = i_valid && o_ready;
  assign o_head  = r_mem[r_rptr];
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_id;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (i_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module arashi_ctrl_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req_valid,
  input  logic             wr_req_id,
  output logic             wr_req_ready,
  input  logic             rd_req_valid,
  input  logic             rd_req_id,
  output logic             rd_req_ready,
  input  logic             ctrl_stall,
  output logic [3:0]       ctrl,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);
  logic       w_wr_head, w_rd_head;
  logic       w_wr_ne, w_rd_ne;
  logic       w_wr_pop, w_rd_pop;
  logic [3:0] r_ctrl;

  arashi_ctrl_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_wr_q (
    .clk(clk), .rst_n(rst_n), .i_valid(wr_req_valid), .i_id(wr_req_id), .i_pop(w_wr_pop),
    .o_ready(wr_req_ready), .o_head(w_wr_head), .o_cnt(wr_cnt)
  );

  arashi_ctrl_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_rd_q (
    .clk(clk), .rst_n(rst_n), .i_valid(rd_req_valid), .i_id(rd_req_id), .i_pop(w_rd_pop),
    .o_ready(rd_req_ready), .o_head(w_rd_head), .o_cnt(rd_cnt)
  );

  assign w_wr_ne = (wr_cnt != '0);
  assign w_rd_ne = (rd_cnt != '0);

`ifdef ARASHI_CTRL_ENC_EXCL_EN
  logic r_prio_wr;
  logic w_both;

  // Contention only when both sides have work; a lone side issues without moving priority
  assign w_both   = w_wr_ne && w_rd_ne;
  assign w_wr_pop = !ctrl_stall && w_wr_ne && (!w_both || r_prio_wr);
  assign w_rd_pop = !ctrl_stall && w_rd_ne && (!w_both || !r_prio_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_prio_wr <= 1'b1;
    else if (w_both && !ctrl_stall) r_prio_wr <= !r_prio_wr;
  end
`else
  assign w_wr_pop = !ctrl_stall && w_wr_ne;
  assign w_rd_pop = !ctrl_stall && w_rd_ne;
`endif

  // Under stall the word is held so the downstream consumes it once stall drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_ctrl <= 4'b0000;
    else if (!ctrl_stall) r_ctrl <= {w_wr_pop & w_wr_head, w_rd_pop & w_rd_head, w_wr_pop, w_rd_pop};
  end

  assign ctrl = r_ctrl;
endmodule
